tohost_monitor: RTL

Memory-mapped test-completion responder on the core's data-store path. It captures riscv-tests `tohost` writes and decodes pass, fail and the failing test number. It runs a cycle watchdog and buffers console characters written to a `putc` address. The simulation top reads its sticky status outputs instead of probing `gp`.

---
 rtl/tohost_monitor.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/tohost_monitor.sv
// riscv-tests tohost responder: decodes PASS/FAIL, runs a RUN-state cycle watchdog
// and buffers putc console bytes. Define TOHOST_WATCHDOG_EN to compile in the TIMEOUT watchdog.
module tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter logic [31:0] PUTC_ADDR      = 32'h0000_1004,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic        done,
  output logic        passed,
  output logic        failed,
  output logic        timeout,
  output logic [30:0] fail_test,
  output logic [31:0] cycle_count,
  output logic        putc_valid,
  output logic [7:0]  putc_data,
  input  logic        putc_ready
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("tohost_monitor: TIMEOUT_CYCLES must be >= 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("tohost_monitor: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   cycle_count_q, cycle_count_d;
  logic [30:0]   fail_test_q, fail_test_d;
  logic          done_q, done_d;
  logic          passed_q, passed_d;
  logic          failed_q, failed_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic fifo_full, fifo_empty;
  logic accept, hit_putc, hit_tohost;
  logic push, pop, term_pass, term_fail, wd_fire;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);

  // Backpressure only from a full FIFO; a same-cycle pop deliberately does not unblock.
  assign hit_putc   = (wr_addr == PUTC_ADDR);
  assign hit_tohost = (wr_addr == TOHOST_ADDR);
  assign wr_ready   = !(hit_putc && fifo_full);
  assign accept     = wr_valid && wr_ready;

  assign push = accept && hit_putc && wr_strb[0] && !clear;
  assign pop  = !fifo_empty && putc_ready && !clear;

  assign term_pass = accept && hit_tohost && (wr_strb == 4'hF) && (wr_data == 32'd1);
  assign term_fail = accept && hit_tohost && (wr_strb == 4'hF) && wr_data[0] && (wr_data != 32'd1);

`ifdef TOHOST_WATCHDOG_EN
  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);
  assign wd_fire = (state_q == ST_RUN) && (cycle_count_q == WD_LIMIT);
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    fail_test_d   = fail_test_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (clear) begin
      state_d       = ST_RUN;
      cycle_count_d = '0;
      fail_test_d   = '0;
      mem_d         = '{default: '0};
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data[7:0];
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      // The terminating edge (tohost or watchdog) does not advance the counter.
      if (state_q == ST_RUN) begin
        if (term_pass) begin
          state_d = ST_PASS;
        end else if (term_fail) begin
          state_d     = ST_FAIL;
          fail_test_d = wr_data[31:1];
        end else if (wd_fire) begin
          state_d = ST_TIMEOUT;
        end else if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + 32'd1;
        end
      end
    end

    done_d    = (state_d != ST_RUN);
    passed_d  = (state_d == ST_PASS);
    failed_d  = (state_d == ST_FAIL);
`ifdef TOHOST_WATCHDOG_EN
    timeout_d = (state_d == ST_TIMEOUT);
`else
    timeout_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      cycle_count_q <= '0;
      fail_test_q   <= '0;
      done_q        <= 1'b0;
      passed_q      <= 1'b0;
      failed_q      <= 1'b0;
      timeout_q     <= 1'b0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      fail_test_q   <= fail_test_d;
      done_q        <= done_d;
      passed_q      <= passed_d;
      failed_q      <= failed_d;
      timeout_q     <= timeout_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  assign done        = done_q;
  assign passed      = passed_q;
  assign failed      = failed_q;
  assign timeout     = timeout_q;
  assign fail_test   = fail_test_q;
  assign cycle_count = cycle_count_q;
  assign putc_valid  = !fifo_empty;
  assign putc_data   = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule
